mux_scan_ctrl: RTL and testbench

- Sequencer that sits in front of the 8:1 mux stage (mux_8x1) and also consumes its output.
- Accepts an 8-bit word over a valid/ready handshake and drives that word onto the mux data inputs. It then steps the mux select through 0..7, holding each select for a programmable dwell.
- Samples the mux output once per select and emits the bits as a serial stream, LSB first. It also reassembles the word and flags any mismatch against the word it drove.
- Used as the mux loopback/serializer stage.

---
 rtl/mux_scan_ctrl.sv | 112 +++++++++++
 tb/tb_mux_scan_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: drives a word onto an 8:1 mux, scans every select, serializes y and checks the loopback
module mux_scan_ctrl #(
   parameter int DWELL = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic [7:0] i_out,
   output logic [2:0] sel_out,
   input  logic       y_in,
   output logic       ser_valid,
   output logic       ser_bit,
   output logic       ser_last,
   output logic [7:0] rx_word,
   output logic       done,
   output logic       mismatch
);
   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW-1:0] DMAX = DW'(DWELL - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t        state_q, state_d;
   logic [7:0]    i_out_q, i_out_d;
   logic [2:0]    sel_q, sel_d;
   logic [7:0]    rx_q, rx_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic          ser_valid_q, ser_valid_d;
   logic          ser_bit_q, ser_bit_d;
   logic          ser_last_q, ser_last_d;
   logic          done_q, done_d;
   logic          mismatch_q, mismatch_d;

   always_comb begin
      state_d     = state_q;
      i_out_d     = i_out_q;
      sel_d       = sel_q;
      rx_d        = rx_q;
      dwell_d     = dwell_q;
      ser_valid_d = 1'b0;
      ser_bit_d   = ser_bit_q;
      ser_last_d  = 1'b0;
      done_d      = 1'b0;
      mismatch_d  = mismatch_q;
      unique case (state_q)
         IDLE: if (in_valid) begin
            i_out_d    = in_data;
            sel_d      = 3'd0;
            dwell_d    = '0;
            rx_d       = 8'h00;
            mismatch_d = 1'b0;
            state_d    = SCAN;
         end
         SCAN: if (dwell_q == DMAX) begin
            // sample only after the mux has had the full dwell to settle on this select
            ser_bit_d   = y_in;
            ser_valid_d = 1'b1;
            ser_last_d  = (sel_q == 3'd7);
            rx_d[sel_q] = y_in;
            dwell_d     = '0;
            state_d     = (sel_q == 3'd7) ? DONE : SCAN;
            sel_d       = (sel_q == 3'd7) ? sel_q : sel_q + 3'd1;
         end else begin
            dwell_d = dwell_q + 1'b1;
         end
         DONE: begin
            done_d     = 1'b1;
            mismatch_d = (rx_q != i_out_q);
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         i_out_q     <= 8'h00;
         sel_q       <= 3'd0;
         rx_q        <= 8'h00;
         dwell_q     <= '0;
         ser_valid_q <= 1'b0;
         ser_bit_q   <= 1'b0;
         ser_last_q  <= 1'b0;
         done_q      <= 1'b0;
         mismatch_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         i_out_q     <= i_out_d;
         sel_q       <= sel_d;
         rx_q        <= rx_d;
         dwell_q     <= dwell_d;
         ser_valid_q <= ser_valid_d;
         ser_bit_q   <= ser_bit_d;
         ser_last_q  <= ser_last_d;
         done_q      <= done_d;
         mismatch_q  <= mismatch_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign i_out     = i_out_q;
   assign sel_out   = sel_q;
   assign rx_word   = rx_q;
   assign ser_valid = ser_valid_q;
   assign ser_bit   = ser_bit_q;
   assign ser_last  = ser_last_q;
   assign done      = done_q;
   assign mismatch  = mismatch_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed loopback tests for mux_scan_ctrl at DWELL=1 and DWELL=3
module tb_mux_scan_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       which = 1'b0;
   logic       tie0 = 1'b0;

   logic       rdy1, sv1, sb1, sl1, dn1, mm1, y1;
   logic [7:0] io1, rx1;
   logic [2:0] sel1;
   logic       rdy3, sv3, sb3, sl3, dn3, mm3, y3;
   logic [7:0] io3, rx3;
   logic [2:0] sel3;

   always #5 clk = ~clk;

   assign y1 = tie0 ? 1'b0 : io1[sel1];
   assign y3 = io3[sel3];

   mux_scan_ctrl #(.DWELL(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid & ~which), .in_ready(rdy1), .in_data(in_data),
      .i_out(io1), .sel_out(sel1), .y_in(y1), .ser_valid(sv1), .ser_bit(sb1), .ser_last(sl1),
      .rx_word(rx1), .done(dn1), .mismatch(mm1)
   );

   mux_scan_ctrl #(.DWELL(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid & which), .in_ready(rdy3), .in_data(in_data),
      .i_out(io3), .sel_out(sel3), .y_in(y3), .ser_valid(sv3), .ser_bit(sb3), .ser_last(sl3),
      .rx_word(rx3), .done(dn3), .mismatch(mm3)
   );

   logic       rdy, sv, sb, sl, dn, mm;
   logic [7:0] io, rx;
   assign rdy = which ? rdy3 : rdy1;
   assign sv  = which ? sv3 : sv1;
   assign sb  = which ? sb3 : sb1;
   assign sl  = which ? sl3 : sl1;
   assign dn  = which ? dn3 : dn1;
   assign mm  = which ? mm3 : mm1;
   assign io  = which ? io3 : io1;
   assign rx  = which ? rx3 : rx1;

   int pass_cnt = 0;
   int total = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      else pass_cnt++;
   endtask

   logic [7:0] bits;
   int nbits, last_n, last_cnt, first_v, done_n;
   logic gap_ok, mm_done, rdy_done, mm0;
   logic [7:0] rx_done;

   // accept happens at the next posedge; n counts negedges after that edge
   task automatic run(input bit hold, input logic [7:0] nd, input int gap);
      int prev = -1;
      bits = 8'h00; nbits = 0; last_n = -1; last_cnt = 0; first_v = -1; done_n = -1;
      gap_ok = 1'b1; mm_done = 1'bx; rdy_done = 1'bx; rx_done = 8'hxx; mm0 = 1'bx;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (n == 0) begin
            mm0 = mm;
            if (hold) in_data = nd;
            else in_valid = 1'b0;
         end
         if (sv) begin
            if (nbits < 8) bits[nbits] = sb;
            nbits++;
            if (first_v < 0) first_v = n;
            if (prev >= 0 && n - prev != gap) gap_ok = 1'b0;
            prev = n;
         end
         if (sl) begin last_n = n; last_cnt++; end
         if (dn) begin
            done_n = n; mm_done = mm; rdy_done = rdy; rx_done = rx;
            break;
         end
      end
      if (done_n < 0) chk("done_timeout", 0, 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready1", rdy1, 1);
      chk("rst_ready3", rdy3, 1);
      chk("rst_iout", io1, 0);
      chk("rst_sel", sel1, 0);
      chk("rst_rx", rx1, 0);
      chk("rst_flags", {sv1, sb1, sl1, dn1, mm1}, 0);

      // ideal loopback, DWELL=1
      which = 1'b0; in_data = 8'h22; in_valid = 1'b1;
      run(0, 8'h00, 1);
      chk("t1_bits", bits, 8'h22);
      chk("t1_nbits", nbits, 8);
      chk("t1_first", first_v, 1);
      chk("t1_gap", gap_ok, 1);
      chk("t1_last_n", last_n, 8);
      chk("t1_last_cnt", last_cnt, 1);
      chk("t1_done_n", done_n, 9);
      chk("t1_rx", rx_done, 8'h22);
      chk("t1_mm", mm_done, 0);
      chk("t1_ready", rdy_done, 1);
      chk("t1_sel_hold", sel1, 7);

      // y stuck at 0 -> mismatch, held until next accept
      tie0 = 1'b1; in_data = 8'h8F; in_valid = 1'b1;
      run(0, 8'h00, 1);
      chk("t2_bits", bits, 8'h00);
      chk("t2_rx", rx_done, 8'h00);
      chk("t2_mm", mm_done, 1);
      repeat (3) @(negedge clk);
      chk("t2_mm_hold", mm1, 1);
      chk("t2_iout_hold", io1, 8'h8F);
      tie0 = 1'b0; in_data = 8'h22; in_valid = 1'b1;
      run(0, 8'h00, 1);
      chk("t2_mm_clear", mm0, 0);
      chk("t2b_mm", mm_done, 0);

      // DWELL=3
      which = 1'b1; in_data = 8'h6E; in_valid = 1'b1;
      run(0, 8'h00, 3);
      chk("t3_bits", bits, 8'h6E);
      chk("t3_nbits", nbits, 8);
      chk("t3_first", first_v, 3);
      chk("t3_gap", gap_ok, 1);
      chk("t3_last_n", last_n, 24);
      chk("t3_done_n", done_n, 25);
      chk("t3_rx", rx_done, 8'h6E);
      chk("t3_mm", mm_done, 0);
      @(negedge clk);

      // in_valid held, new data during SCAN is dropped, next accept at E10
      which = 1'b0; in_data = 8'h38; in_valid = 1'b1;
      run(1, 8'hFF, 1);
      chk("t4_rx1", rx_done, 8'h38);
      chk("t4_done_n", done_n, 9);
      chk("t4_ready", rdy_done, 1);
      run(0, 8'h00, 1);
      chk("t4_iout2", io1, 8'hFF);
      chk("t4_rx2", rx_done, 8'hFF);
      chk("t4_done2_n", done_n, 9);

      // back-to-back 01 then 80
      in_data = 8'h01; in_valid = 1'b1;
      run(1, 8'h80, 1);
      chk("t6_bits1", bits, 8'h01);
      chk("t6_first1", bits[0], 1);
      chk("t6_lastbit1", bits[7], 0);
      run(0, 8'h00, 1);
      chk("t6_bits2", bits, 8'h80);
      chk("t6_first2", bits[0], 0);
      chk("t6_lastbit2", bits[7], 1);
      chk("t6_done2_n", done_n, 9);

      // reset after the 4th sample, with in_valid colliding
      in_data = 8'h5A; in_valid = 1'b1;
      begin
         int cnt = 0;
         for (int n = 0; n < 20 && cnt < 4; n++) begin
            @(negedge clk);
            if (n == 0) in_valid = 1'b0;
            if (sv1) cnt++;
         end
         chk("t5_reach4", cnt, 4);
      end
      rst = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      chk("t5_iout", io1, 0);
      chk("t5_sel", sel1, 0);
      chk("t5_rx", rx1, 0);
      chk("t5_flags", {sv1, sb1, sl1, dn1, mm1}, 0);
      in_valid = 1'b0; rst = 1'b0;
      begin
         int ev = 0;
         for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (sv1 || dn1) ev++;
         end
         chk("t5_quiet", ev, 0);
      end
      chk("t5_ready", rdy1, 1);
      chk("t5_not_accepted", io1, 0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
